// File: rtl/sys_timer_pkg.sv
// Shared register map, CTRL field layout and decode helpers for the sys_timer block.
package sys_timer_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_LOAD   = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_RELOAD    = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int CTRL_PS_LSB    = 8;
    localparam int CTRL_PS_MSB    = 15;
    localparam int STATUS_EXPIRED = 0;

    typedef enum logic [1:0] {
        REG_CTRL   = OFF_CTRL[3:2],
        REG_LOAD   = OFF_LOAD[3:2],
        REG_COUNT  = OFF_COUNT[3:2],
        REG_STATUS = OFF_STATUS[3:2]
    } reg_sel_e;

    typedef struct packed {
        logic [7:0] prescale;
        logic       irq_en;
        logic       reload;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN]                  = c.en;
        v[CTRL_RELOAD]              = c.reload;
        v[CTRL_IRQ_EN]              = c.irq_en;
        v[CTRL_PS_MSB:CTRL_PS_LSB]  = c.prescale;
        return v;
    endfunction

    function automatic ctrl_t ctrl_unpack(input logic [31:0] v);
        ctrl_t c;
        c.en       = v[CTRL_EN];
        c.reload   = v[CTRL_RELOAD];
        c.irq_en   = v[CTRL_IRQ_EN];
        c.prescale = v[CTRL_PS_MSB:CTRL_PS_LSB];
        return c;
    endfunction

    // The window is 16 bytes, so only the upper 28 address bits take part in the match.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:4] == base[31:4];
    endfunction

endpackage

// File: rtl/sys_timer_prescaler.sv
// 8-bit prescaler: produces a one-cycle tick every (limit + 1) enabled cycles.
module sys_timer_prescaler
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    input  logic [7:0] limit,
    output logic       tick
);

    logic [7:0] r_cnt;
    logic       w_hit;

    assign w_hit = (r_cnt == limit);
    assign tick  = en && w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || restart || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped down-counting timer on the sys bus: CTRL/LOAD/COUNT/STATUS registers,
// prescaled countdown, sticky expiry flag and level interrupt.
module sys_timer
    import sys_timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_0100
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sys_w_addr,
    input  logic [31:0] sys_w_line,
    input  logic        sys_write,
    input  logic [31:0] sys_r_addr,
    input  logic        sys_read,
    output logic [31:0] sys_r_line,
    output logic        irq
);

    ctrl_t       r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_expired;
    logic [31:0] r_rdata;

    reg_sel_e    w_wreg;
    reg_sel_e    w_rreg;
    logic        w_wsel;
    logic        w_rsel;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_expire;
    logic        w_restart;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = ^{sys_w_addr[1:0], sys_r_addr[1:0]};

    assign w_wsel      = sys_write && addr_hit(sys_w_addr, BASE);
    assign w_rsel      = sys_read && addr_hit(sys_r_addr, BASE);
    assign w_wreg      = reg_sel_e'(sys_w_addr[3:2]);
    assign w_rreg      = reg_sel_e'(sys_r_addr[3:2]);
    assign w_wr_ctrl   = w_wsel && (w_wreg == REG_CTRL);
    assign w_wr_load   = w_wsel && (w_wreg == REG_LOAD);
    assign w_wr_count  = w_wsel && (w_wreg == REG_COUNT);
    assign w_wr_status = w_wsel && (w_wreg == REG_STATUS);

    // Only a genuine 0->1 enable transition restarts the prescale phase.
    assign w_restart = w_wr_ctrl && sys_w_line[CTRL_EN] && !r_ctrl.en;
    assign w_expire  = w_tick && (r_count == 32'd0);

    sys_timer_prescaler u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (r_ctrl.en),
        .restart (w_restart),
        .limit   (r_ctrl.prescale),
        .tick    (w_tick)
    );

    // A CTRL write is taken verbatim, so it overrides the one-shot auto-disable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= ctrl_unpack(sys_w_line);
        end else if (w_expire && !r_ctrl.reload) begin
            r_ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load <= '0;
        end else if (w_wr_load) begin
            r_load <= sys_w_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= sys_w_line;
        end else if (w_tick) begin
            if (r_count != 32'd0) begin
                r_count <= r_count - 32'd1;
            end else if (r_ctrl.reload) begin
                r_count <= r_load;
            end
        end
    end

    // Expiry has priority over a write-1-clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_status && sys_w_line[STATUS_EXPIRED]) begin
            r_expired <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rsel) begin
            case (w_rreg)
                REG_CTRL:   w_rdata = ctrl_pack(r_ctrl);
                REG_LOAD:   w_rdata = r_load;
                REG_COUNT:  w_rdata = r_count;
                REG_STATUS: w_rdata[STATUS_EXPIRED] = r_expired;
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign sys_r_line = r_rdata;
    assign irq        = r_expired && r_ctrl.irq_en;

endmodule

// File: tb/tb_sys_timer.sv
// Directed scoreboard bench for sys_timer: drivers queue expected read data / irq levels,
// a negedge monitor pops and compares one cycle after each request.
module tb_sys_timer;

    localparam logic [31:0] BASE     = 32'h0000_0100;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_LOAD   = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sys_w_addr = '0;
    logic [31:0] sys_w_line = '0;
    logic        sys_write = 1'b0;
    logic [31:0] sys_r_addr = '0;
    logic        sys_read = 1'b0;
    logic [31:0] sys_r_line;
    logic        irq;

    always #5 clk = ~clk;

    sys_timer #(.BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .sys_w_addr (sys_w_addr),
        .sys_w_line (sys_w_line),
        .sys_write  (sys_write),
        .sys_r_addr (sys_r_addr),
        .sys_read   (sys_read),
        .sys_r_line (sys_r_line),
        .irq        (irq)
    );

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        irq_q[$];
    string       irq_name_q[$];

    int    n_vec = 0;
    int    n_mis = 0;
    logic  rd_v = 1'b0;
    logic  irq_v = 1'b0;
    logic  drv_irq_chk = 1'b0;
    bit    mon_on = 1'b0;
    bit    done = 1'b0;
    bit    fin_chk = 1'b0;
    logic [31:0] m_exp;
    logic        m_iexp;
    string       m_nm;

    always @(posedge clk) begin
        rd_v  <= sys_read;
        irq_v <= drv_irq_chk;
    end

    // Monitor: sole owner of the comparison counters.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_v) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL rd_unexpected: got %h, no expected entry", sys_r_line);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_nm  = name_q.pop_front();
                    if (sys_r_line !== m_exp) begin
                        n_mis++;
                        $display("FAIL %s: sys_r_line=%h expected %h", m_nm, sys_r_line, m_exp);
                    end
                end
            end else begin
                n_vec++;
                if (sys_r_line !== 32'h0) begin
                    n_mis++;
                    $display("FAIL rd_idle: sys_r_line=%h expected 00000000", sys_r_line);
                end
            end
            if (irq_v) begin
                n_vec++;
                if (irq_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL irq_unexpected: irq=%b, no expected entry", irq);
                end else begin
                    m_iexp = irq_q.pop_front();
                    m_nm   = irq_name_q.pop_front();
                    if (irq !== m_iexp) begin
                        n_mis++;
                        $display("FAIL %s: irq=%b expected %b", m_nm, irq, m_iexp);
                    end
                end
            end
            if (done && !fin_chk) begin
                fin_chk = 1'b1;
                n_vec++;
                if (exp_q.size() != 0 || irq_q.size() != 0) begin
                    n_mis++;
                    $display("FAIL drain: %0d reads and %0d irq checks left, expected 0",
                             exp_q.size(), irq_q.size());
                end
            end
        end
    end

    // One bus cycle; ci requests an irq check of the state after this cycle's edge.
    task automatic cyc(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                       input logic r, input logic [31:0] ra, input logic [31:0] re,
                       input string nm, input logic ci, input logic ie);
        @(negedge clk);
        rst        = 1'b0;
        sys_write  = w;
        sys_w_addr = wa;
        sys_w_line = wd;
        sys_read   = r;
        sys_r_addr = ra;
        drv_irq_chk = ci;
        if (r) begin
            exp_q.push_back(re);
            name_q.push_back(nm);
        end
        if (ci) begin
            irq_q.push_back(ie);
            irq_name_q.push_back({nm, "_irq"});
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, a, d, 1'b0, 32'h0, 32'h0, "", 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, a, e, nm, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, "", 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        mon_on = 1'b1;

        // Reset state
        cyc(1'b0, 32'h0, 32'h0, 1'b1, A_CTRL, 32'h0, "rst_ctrl", 1'b1, 1'b0);
        rd(A_LOAD,   32'h0, "rst_load");
        rd(A_COUNT,  32'h0, "rst_count");
        rd(A_STATUS, 32'h0, "rst_status");

        // One-shot, prescale 0, count 3
        wr(A_COUNT, 32'd3);
        cyc(1'b1, A_CTRL, 32'h5, 1'b1, A_COUNT, 32'd3, "os_cnt3a", 1'b0, 1'b0);
        rd(A_COUNT, 32'd3, "os_cnt3b");
        rd(A_COUNT, 32'd2, "os_cnt2");
        cyc(1'b0, 32'h0, 32'h0, 1'b1, A_COUNT, 32'd1, "os_cnt1", 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, A_COUNT, 32'd0, "os_cnt0", 1'b1, 1'b1);
        rd(A_STATUS, 32'h1, "os_expired");
        rd(A_CTRL,   32'h4, "os_en_cleared");
        rd(A_COUNT,  32'h0, "os_cnt_hold");
        wr(A_STATUS, 32'h1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, A_STATUS, 32'h0, "os_clr", 1'b1, 1'b0);

        // Periodic, LOAD 1, COUNT 1, PRESCALE 2: expiry every 6 cycles
        wr(A_LOAD, 32'd1);
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'h0000_0203);
        for (int i = 0; i < 6; i++) rd(A_STATUS, 32'h0, "per_pre");
        rd(A_STATUS, 32'h1, "per_exp1");
        cyc(1'b1, A_STATUS, 32'h1, 1'b1, A_STATUS, 32'h1, "per_exp1_hold", 1'b0, 1'b0);
        rd(A_STATUS, 32'h0, "per_clr");
        rd(A_COUNT,  32'h0, "per_cnt_a");
        rd(A_COUNT,  32'h0, "per_cnt_b");
        cyc(1'b1, A_STATUS, 32'h1, 1'b1, A_STATUS, 32'h0, "per_pre2", 1'b0, 1'b0);
        rd(A_STATUS, 32'h1, "per_exp_beats_clr");
        rd(A_COUNT,  32'h1, "per_reload");

        // COUNT write on a tick edge beats the decrement
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        wr(A_COUNT, 32'd10);
        wr(A_CTRL, 32'h1);
        idle(1);
        wr(A_COUNT, 32'd100);
        rd(A_COUNT, 32'd100, "sw_cnt_wins");
        rd(A_COUNT, 32'd99,  "sw_cnt_dec");
        wr(A_CTRL, 32'h0);

        // Field masking, unselected addresses, read-during-write
        wr(A_CTRL, 32'hFFFF_0AF6);
        wr(A_LOAD, 32'h66);
        wr(A_COUNT, 32'h55);
        wr(BASE + 32'h10, 32'hFFFF_FFFF);
        wr(BASE - 32'h4,  32'hFFFF_FFFF);
        wr(BASE + 32'h1000, 32'hFFFF_FFFF);
        rd(BASE + 32'h10, 32'h0, "unsel_hi");
        rd(BASE - 32'h4,  32'h0, "unsel_lo");
        rd(A_CTRL, 32'h0000_0A06, "ctrl_mask");
        rd(BASE + 32'h7, 32'h66, "load_lowbits");
        rd(A_COUNT, 32'h55, "count_kept");
        cyc(1'b0, 32'h0, 32'h0, 1'b1, A_STATUS, 32'h0, "status_kept", 1'b1, 1'b0);
        cyc(1'b1, A_COUNT, 32'h77, 1'b1, A_COUNT, 32'h55, "rdw_old", 1'b0, 1'b0);
        rd(A_COUNT, 32'h77, "rdw_new");

        // Reset mid-count wins over a simultaneous write
        wr(A_LOAD, 32'd7);
        wr(A_COUNT, 32'd50);
        wr(A_CTRL, 32'h5);
        idle(3);
        @(negedge clk);
        rst        = 1'b1;
        sys_write  = 1'b1;
        sys_w_addr = A_COUNT;
        sys_w_line = 32'd9;
        sys_read   = 1'b0;
        drv_irq_chk = 1'b0;
        rd(A_CTRL,  32'h0, "mrst_ctrl");
        rd(A_LOAD,  32'h0, "mrst_load");
        rd(A_COUNT, 32'h0, "mrst_count");
        cyc(1'b0, 32'h0, 32'h0, 1'b1, A_STATUS, 32'h0, "mrst_status", 1'b1, 1'b0);
        idle(4);
        rd(A_COUNT, 32'h0, "mrst_no_dec");

        idle(3);
        done = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
